// File: rtl/sdram_pkg.sv
// Shared encodings and types for the SDR SDRAM device-side responder.
// Commands are {cs, ras, cas, we}; error codes are reported on err_code.
package sdram_pkg;

   localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
   localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
   localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
   localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
   localparam logic [3:0] CMD_WRITE        = 4'b0100;
   localparam logic [3:0] CMD_READ         = 4'b0101;
   localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;
   localparam logic [3:0] CMD_NOP          = 4'b0111;

   localparam logic [3:0] ERR_NONE          = 4'd0;
   localparam logic [3:0] ERR_MODE_OPEN     = 4'd1;
   localparam logic [3:0] ERR_MODE_CL       = 4'd2;
   localparam logic [3:0] ERR_MODE_BL       = 4'd3;
   localparam logic [3:0] ERR_ACT_OPEN      = 4'd4;
   localparam logic [3:0] ERR_TRP           = 4'd5;
   localparam logic [3:0] ERR_NO_MODE       = 4'd6;
   localparam logic [3:0] ERR_BANK_IDLE     = 4'd7;
   localparam logic [3:0] ERR_TRCD          = 4'd8;
   localparam logic [3:0] ERR_WR_IN_FLIGHT  = 4'd9;
   localparam logic [3:0] ERR_REF_OPEN      = 4'd10;

   localparam int MODE_CL_LSB = 4;
   localparam int MODE_CL_MSB = 6;
   localparam int MODE_BL_LSB = 0;
   localparam int MODE_BL_MSB = 2;
   localparam int ADDR_A10    = 10;

   localparam int CNT_W = 4;

   typedef enum logic {
      DEV_INIT,
      DEV_READY
   } dev_state_e;

   typedef struct packed {
      logic             isOpen;
      logic [12:0]      row;
      logic [CNT_W-1:0] trcdCnt;
      logic [CNT_W-1:0] trpCnt;
   } bank_t;

   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sdram_bank_tracker.sv
// Per-bank open/row state plus saturating clocks-since-ACTIVE and
// clocks-since-PRECHARGE counters.
module sdram_bank_tracker
   import sdram_pkg::*;
#(
   parameter int TRCD = 3,
   parameter int TRP  = 2
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        activate_i,
   input  logic [12:0] row_i,
   input  logic        precharge_i,
   output logic        open_o,
   output logic [12:0] row_o,
   output logic        trcdOk_o,
   output logic        trpOk_o
);

   bank_t bank_q, bank_d;

   // Precharging an already idle bank leaves its tRP count running.
   always_comb begin
      bank_d         = bank_q;
      bank_d.trcdCnt = satInc(bank_q.trcdCnt);
      bank_d.trpCnt  = satInc(bank_q.trpCnt);
      if (activate_i) begin
         bank_d.isOpen  = 1'b1;
         bank_d.row     = row_i;
         bank_d.trcdCnt = '0;
      end else if (precharge_i && bank_q.isOpen) begin
         bank_d.isOpen = 1'b0;
         bank_d.trpCnt = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_q.isOpen  <= 1'b0;
         bank_q.row     <= '0;
         bank_q.trcdCnt <= '0;
         bank_q.trpCnt  <= '1;
      end else begin
         bank_q <= bank_d;
      end
   end

   // A count of N at a sampling edge means N+1 clocks have elapsed.
   assign trcdOk_o = (int'(bank_q.trcdCnt) >= TRCD - 1);
   assign trpOk_o  = (int'(bank_q.trpCnt) >= TRP - 1);
   assign open_o   = bank_q.isOpen;
   assign row_o    = bank_q.row;

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM model: command decode, bank tracking, CAS-latency
// read pipeline, byte-masked word store and sticky protocol error capture.
module sdram_responder
   import sdram_pkg::*;
#(
   parameter int MEM_AW = 12,
   parameter int TRCD   = 3,
   parameter int TRP    = 2
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sd_cs,
   input  logic        sd_ras,
   input  logic        sd_cas,
   input  logic        sd_we,
   input  logic [1:0]  sd_ba,
   input  logic [12:0] sd_addr,
   input  logic [1:0]  sd_dqm,
   input  logic [15:0] sd_dq_in,
   output logic [15:0] sd_dq_out,
   output logic        sd_dq_oe,
   output logic [15:0] refresh_cnt,
   output logic        err,
   output logic [3:0]  err_code
);

   logic [3:0]        cmd;
   logic [3:0]        bankOpen, bankTrcdOk, bankTrpOk;
   logic [12:0]       bankRow [4];
   logic [3:0]        doActivate, doPrecharge;
   logic              doWrite, doRead, doLoadMode, doRefresh, doFlush;
   logic [3:0]        cmdErr;
   logic [2:0]        modeCl;
   logic [MEM_AW-1:0] wordIdx;
   logic              modeValid, clIs3, inFlight;

   dev_state_e        devState_q;
   logic [2:0]        cl_q;
   logic [15:0]       refreshCnt_q;
   logic              err_q;
   logic [3:0]        errCode_q;
   logic [2:0]        rdValid_q;
   logic [15:0]       rdWord_q, rdData1_q, rdData2_q, dqOut_q;
   logic              dqOe_q;
   logic [15:0]       mem [2**MEM_AW];

   assign cmd       = {sd_cs, sd_ras, sd_cas, sd_we};
   assign modeCl    = sd_addr[MODE_CL_MSB:MODE_CL_LSB];
   assign wordIdx   = MEM_AW'({sd_ba, bankRow[sd_ba], sd_addr[8:0]});
   assign modeValid = (devState_q == DEV_READY);
   assign clIs3     = (cl_q == 3'd3);
   assign inFlight  = rdValid_q[0] | rdValid_q[1] | (clIs3 & rdValid_q[2]);

   for (genvar b = 0; b < 4; b++) begin : gBank
      sdram_bank_tracker #(.TRCD(TRCD), .TRP(TRP)) uBank (
         .clk         (clk),
         .reset_n     (reset_n),
         .activate_i  (doActivate[b]),
         .row_i       (sd_addr),
         .precharge_i (doPrecharge[b]),
         .open_o      (bankOpen[b]),
         .row_o       (bankRow[b]),
         .trcdOk_o    (bankTrcdOk[b]),
         .trpOk_o     (bankTrpOk[b])
      );
   end

   // Checks are ordered so the lowest applicable error code wins.
   always_comb begin
      cmdErr      = ERR_NONE;
      doActivate  = '0;
      doPrecharge = '0;
      doWrite     = 1'b0;
      doRead      = 1'b0;
      doLoadMode  = 1'b0;
      doRefresh   = 1'b0;
      doFlush     = 1'b0;
      case (cmd)
         CMD_LOAD_MODE: begin
            if (|bankOpen)                          cmdErr = ERR_MODE_OPEN;
            else if (modeCl != 3'd2 && modeCl != 3'd3) cmdErr = ERR_MODE_CL;
            else if (sd_addr[MODE_BL_MSB:MODE_BL_LSB] != 3'd0) cmdErr = ERR_MODE_BL;
            else                                    doLoadMode = 1'b1;
         end
         CMD_ACTIVE: begin
            if (bankOpen[sd_ba])         cmdErr = ERR_ACT_OPEN;
            else if (!bankTrpOk[sd_ba])  cmdErr = ERR_TRP;
            else                         doActivate[sd_ba] = 1'b1;
         end
         CMD_READ, CMD_WRITE: begin
            if (!modeValid)               cmdErr = ERR_NO_MODE;
            else if (!bankOpen[sd_ba])    cmdErr = ERR_BANK_IDLE;
            else if (!bankTrcdOk[sd_ba])  cmdErr = ERR_TRCD;
            else begin
               if (cmd == CMD_WRITE) begin
                  if (inFlight) cmdErr = ERR_WR_IN_FLIGHT;
                  doWrite = 1'b1;
               end else begin
                  doRead = 1'b1;
               end
               doPrecharge[sd_ba] = sd_addr[ADDR_A10];
            end
         end
         CMD_PRECHARGE: begin
            if (sd_addr[ADDR_A10]) doPrecharge = '1;
            else                   doPrecharge[sd_ba] = 1'b1;
         end
         CMD_AUTO_REFRESH: begin
            if (!(&bankTrpOk))  cmdErr = ERR_TRP;
            else if (|bankOpen) cmdErr = ERR_REF_OPEN;
            else                doRefresh = 1'b1;
         end
         CMD_BURST_TERM: doFlush = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (doWrite) begin
         if (!sd_dqm[0]) mem[wordIdx][7:0]  <= sd_dq_in[7:0];
         if (!sd_dqm[1]) mem[wordIdx][15:8] <= sd_dq_in[15:8];
      end
      if (doRead) rdWord_q <= mem[wordIdx];
   end

   // Stage 0 is the RAM output; CL picks whether stage 1 or 2 feeds the pad.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdValid_q <= '0;
         rdData1_q <= '0;
         rdData2_q <= '0;
         dqOut_q   <= '0;
         dqOe_q    <= 1'b0;
      end else if (doFlush) begin
         rdValid_q <= '0;
         dqOe_q    <= 1'b0;
      end else begin
         rdValid_q <= {rdValid_q[1:0], doRead};
         rdData1_q <= rdWord_q;
         rdData2_q <= rdData1_q;
         dqOe_q    <= clIs3 ? rdValid_q[2] : rdValid_q[1];
         if (clIs3 ? rdValid_q[2] : rdValid_q[1]) begin
            dqOut_q <= clIs3 ? rdData2_q : rdData1_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         devState_q   <= DEV_INIT;
         cl_q         <= 3'd3;
         refreshCnt_q <= '0;
         err_q        <= 1'b0;
         errCode_q    <= ERR_NONE;
      end else begin
         if (doLoadMode) begin
            devState_q <= DEV_READY;
            cl_q       <= modeCl;
         end
         if (doRefresh && !(&refreshCnt_q)) refreshCnt_q <= refreshCnt_q + 16'd1;
         if (cmdErr != ERR_NONE && !err_q) begin
            err_q     <= 1'b1;
            errCode_q <= cmdErr;
         end
      end
   end

   assign sd_dq_out   = dqOut_q;
   assign sd_dq_oe    = dqOe_q;
   assign refresh_cnt = refreshCnt_q;
   assign err         = err_q;
   assign err_code    = errCode_q;

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable responder for the SDR SDRAM command bus, modelling the device side of an MT48LC16M16-style chip.
- Decodes CS/RAS/CAS/WE commands, tracks the open row per bank, and honours the mode register's CAS latency.
- Serves reads and writes from a small on-chip word store.
- Flags protocol violations: timing, bank state, mode.
- Used in FPGA self-test builds and benches as the far end of our SDRAM controller, without an external chip.

Parameters:
- MEM_AW, 12, word-address bits of the backing store (2^MEM_AW x 16-bit words).
- TRCD, 3, minimum clocks from ACTIVE to READ/WRITE on the same bank.
- TRP, 2, minimum clocks from PRECHARGE to ACTIVE/AUTO_REFRESH.

Ports:
- clk  in  1  device clock; all sampling on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- sd_cs  in  1  chip select, active low.
- sd_ras  in  1  row address strobe, active low.
- sd_cas  in  1  column address strobe, active low.
- sd_we  in  1  write enable, active low.
- sd_ba  in  2  bank address.
- sd_addr  in  13  multiplexed address; A10 = precharge-all / auto-precharge.
- sd_dqm  in  2  byte masks: [1] = upper byte, [0] = lower byte; 1 = masked.
- sd_dq_in  in  16  data from controller.
- sd_dq_out  out  16  read data.
- sd_dq_oe  out  1  high while sd_dq_out must drive the pad.
- refresh_cnt  out  16  AUTO_REFRESH commands seen; saturates at 0xFFFF.
- err  out  1  sticky protocol-error flag.
- err_code  out  4  code of the first error; held until reset.

Behaviour:
- Reset (async, reset_n=0):
  - all banks closed; mode_valid=0; CL=3.
  - read pipeline empty; sd_dq_oe=0; sd_dq_out=0.
  - refresh_cnt=0; err=0; err_code=0.
  - Store contents are not reset.
- Command decode: {cs,ras,cas,we}, taken only when cs=0.
  - cs=1 (INHIBIT) and 0111 (NOP): no action.
  - 0011 ACTIVE, 0101 READ, 0100 WRITE, 0010 PRECHARGE, 0001 AUTO_REFRESH, 0000 LOAD_MODE.
  - 0110 BURST_TERMINATE: flush the read pipeline.
- States: device FSM is INIT (mode_valid=0) -> READY after the first legal LOAD_MODE. Per-bank FSM is IDLE <-> ACTIVE (row[12:0] register). Per-bank counters track clocks since ACTIVE (tRCD) and since PRECHARGE (tRP); both saturate.
- LOAD_MODE:
  - Legal only when all banks are IDLE, else error 1.
  - CL=addr[6:4]; only 2 or 3 accepted, else error 2 and mode unchanged.
  - Burst length addr[2:0] must be 000, else error 3.
  - On success, mode_valid=1.
- ACTIVE:
  - Bank must be IDLE (error 4) and its tRP count >= TRP (error 5).
  - Opens the bank with row=sd_addr and clears its tRCD counter.
- READ/WRITE:
  - Require mode_valid (error 6), bank ACTIVE (error 7), and tRCD count >= TRCD (error 8).
  - Column = sd_addr[8:0].
  - Word index = {ba, row, col} truncated to its low MEM_AW bits.
  - A10=1: auto-precharge; the bank goes IDLE the cycle after the command and its tRP counter starts.
- WRITE:
  - Store updated on the command edge from sd_dq_in.
  - Each byte is written only where its dqm bit = 0.
- READ:
  - Word fetched and pushed into a CL-deep pipeline.
  - sd_dq_oe=1 and sd_dq_out=word exactly CL clocks after the READ edge, for one clock.
  - Read DQM is ignored; both lanes are always driven.
  - Back-to-back READs stream one word per clock.
  - A WRITE while read data is still in flight gives error 9; the write still happens.
- PRECHARGE:
  - A10=1: all banks. A10=0: sd_ba only.
  - Precharging an IDLE bank is legal: no error, counter not restarted.
- AUTO_REFRESH:
  - All banks must be IDLE (error 10) and past tRP (error 5).
  - refresh_cnt increments.
- Simultaneous errors: lowest code wins. A command that errors has no side effect unless stated above.
- reset_n asserted mid-read: pipeline cleared immediately and sd_dq_oe drops asynchronously.

Decomposition:
- Package sdram_pkg holds:
  - CMD_* 4-bit encodings.
  - ERR_* codes 1..10.
  - Mode-field bit positions.
  - Bank record type (open flag, row, tRCD count, tRP count).
- One sub-module, sdram_bank_tracker, instantiated x4. It holds per-bank state and counters and outputs open/row/trcd_ok/trp_ok.
- The store is an inferred single-port RAM with byte enables.

Test Plan:
- Init: PRECHARGE A10=1, wait 2, LOAD_MODE 0x230 -> mode_valid=1, CL=3, err=0; two AUTO_REFRESH -> refresh_cnt=2.
- Write/read, CL=3:
  - ACTIVE ba=1 row=0x005, wait 3, WRITE col=0x012 data=0xA55A dqm=00.
  - READ col=0x012 -> sd_dq_oe high exactly 3 clocks later with 0xA55A.
  - Repeat with CL=2 (mode 0x220) -> data 2 clocks later.
- Byte masking: word holds 0xA55A; WRITE 0x1234 with dqm=10, then READ -> 0xA534.
- tRCD violation: ACTIVE then READ after 1 clock -> err=1, err_code=8, sd_dq_oe stays 0.
- Bank-state errors:
  - ACTIVE on an open bank -> err_code=4.
  - After reset, AUTO_REFRESH with bank 0 open -> err_code=10.
- Auto-precharge and reset:
  - READ with A10=1, then ACTIVE on the same bank after TRP -> no error.
  - Assert reset_n during the CL wait -> sd_dq_oe=0 immediately and err=0.
